// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: owns the PC, issues one bundle read per cycle,
// and queues returned bundles in a DEPTH-entry FIFO ahead of the decoder.
module fetch_buffer #(
  parameter int DATA_W = 32,
  parameter int ISSUE  = 2,
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [ISSUE*DATA_W-1:0]      imem_data,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [ISSUE*DATA_W-1:0]      dec_data,
  output logic [PC_W-1:0]              dec_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int BW = ISSUE * DATA_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            infl_q, infl_d;
  logic [PC_W-1:0] infl_pc_q, infl_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [BW-1:0]   data_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];

  logic [CW:0] occ;
  logic        push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The in-flight reservation keeps the FIFO from ever overflowing.
  assign occ = (CW+1)'(count_q) + (CW+1)'(infl_q);
  assign imem_req = !rst && !redirect && (occ < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign dec_valid = (count_q != '0);
  assign dec_data  = data_mem[rd_ptr_q];
  assign dec_pc    = pc_mem[rd_ptr_q];
  assign count     = count_q;

  assign push = infl_q && !redirect;
  assign pop  = dec_valid && dec_ready && !redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_d     = 1'b0;
    infl_pc_d  = infl_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + PC_W'(ISSUE);
        infl_d     = 1'b1;
        infl_pc_d  = fetch_pc_q;
      end
      if (push) wr_ptr_d = nxt(wr_ptr_q);
      if (pop)  rd_ptr_d = nxt(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_data;
      pc_mem[wr_ptr_q]   <= infl_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: vector table for stream, back-pressure and
// redirect, plus hand sequences for async reset and PC wrap.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [63:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [63:0] dec_data;
  logic [31:0] dec_pc;
  logic [2:0]  count;

  logic        rst_w = 1'b1;
  logic        req_w;
  logic [7:0]  addr_w;
  logic [63:0] data_w = '0;
  logic        redir_w = 1'b0;
  logic [7:0]  rpc_w = '0;
  logic        valid_w;
  logic        ready_w = 1'b1;
  logic [63:0] ddata_w;
  logic [7:0]  dpc_w;
  logic [2:0]  count_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_buffer u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_data(dec_data), .dec_pc(dec_pc), .count(count)
  );

  fetch_buffer #(.PC_W(8), .RESET_PC(8'hFE)) u_wrap (
    .clk(clk), .rst(rst_w),
    .imem_req(req_w), .imem_addr(addr_w), .imem_data(data_w),
    .redirect(redir_w), .redirect_pc(rpc_w),
    .dec_valid(valid_w), .dec_ready(ready_w),
    .dec_data(ddata_w), .dec_pc(dpc_w), .count(count_w)
  );

  // Memory returns an address-tagged bundle one cycle after the request.
  always @(posedge clk) begin
    imem_data <= {imem_addr + 32'd1, imem_addr};
    data_w    <= {24'd0, addr_w + 8'd1, 24'd0, addr_w};
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vec [23];

  initial begin
    vec[0]  = '{1, 0, 0,     0, 0,     0, 1, 32'h000};
    vec[1]  = '{1, 0, 0,     0, 0,     0, 1, 32'h002};
    vec[2]  = '{1, 0, 0,     1, 0,     1, 1, 32'h004};
    vec[3]  = '{1, 0, 0,     1, 2,     1, 1, 32'h006};
    vec[4]  = '{0, 0, 0,     1, 4,     1, 1, 32'h008};
    vec[5]  = '{0, 0, 0,     1, 4,     2, 1, 32'h00A};
    vec[6]  = '{0, 0, 0,     1, 4,     3, 0, 32'h00C};
    vec[7]  = '{0, 0, 0,     1, 4,     4, 0, 32'h00C};
    vec[8]  = '{0, 0, 0,     1, 4,     4, 0, 32'h00C};
    vec[9]  = '{1, 0, 0,     1, 4,     4, 0, 32'h00C};
    vec[10] = '{1, 0, 0,     1, 6,     3, 1, 32'h00C};
    vec[11] = '{1, 0, 0,     1, 8,     2, 1, 32'h00E};
    vec[12] = '{1, 0, 0,     1, 10,    2, 1, 32'h010};
    vec[13] = '{0, 0, 0,     1, 12,    2, 1, 32'h012};
    vec[14] = '{0, 1, 32'h100, 1, 12,  3, 0, 32'h014};
    vec[15] = '{1, 0, 0,     0, 0,     0, 1, 32'h100};
    vec[16] = '{1, 0, 0,     0, 0,     0, 1, 32'h102};
    vec[17] = '{1, 0, 0,     1, 32'h100, 1, 1, 32'h104};
    vec[18] = '{1, 1, 32'h40, 1, 32'h102, 1, 0, 32'h106};
    vec[19] = '{1, 0, 0,     0, 0,     0, 1, 32'h040};
    vec[20] = '{1, 0, 0,     0, 0,     0, 1, 32'h042};
    vec[21] = '{1, 0, 0,     1, 32'h40, 1, 1, 32'h044};
    vec[22] = '{1, 0, 0,     1, 32'h42, 1, 1, 32'h046};

    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_count", count, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      dec_ready   = vec[i].rdy;
      redirect    = vec[i].rd;
      redirect_pc = vec[i].rpc;
      #1;
      chk($sformatf("v%0d_valid", i), dec_valid, vec[i].ev);
      chk($sformatf("v%0d_count", i), count, vec[i].ecnt);
      chk($sformatf("v%0d_req", i), imem_req, vec[i].ereq);
      chk($sformatf("v%0d_addr", i), imem_addr, vec[i].eaddr);
      if (vec[i].ev) begin
        chk($sformatf("v%0d_pc", i), dec_pc, vec[i].epc);
        chk($sformatf("v%0d_data", i), dec_data,
            {vec[i].epc + 32'd1, vec[i].epc});
      end
      @(negedge clk);
    end
    redirect  = 1'b0;
    dec_ready = 1'b1;

    // Async reset between edges while the stream is running.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", dec_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_req", imem_req, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rs%0d_valid", c), dec_valid, c >= 2);
      chk($sformatf("rs%0d_count", c), count, (c >= 2) ? 1 : 0);
      if (c >= 2)
        chk($sformatf("rs%0d_pc", c), dec_pc, 32'((c - 2) * 2));
      @(negedge clk);
    end

    // PC wrap on the 8-bit instance.
    rst_w = 1'b1;
    @(negedge clk);
    rst_w = 1'b0;
    chk("wrap_addr0", addr_w, 8'hFE);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("wr%0d_valid", c), valid_w, c >= 2);
      if (c == 2) chk("wrap_pc_fe", dpc_w, 8'hFE);
      if (c == 3) chk("wrap_pc_00", dpc_w, 8'h00);
      if (c == 4) chk("wrap_pc_02", dpc_w, 8'h02);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
